// File: rtl/nco_freq_meter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : nco_pkg
// Brief    : Shared NCO defaults and frequency-meter state encoding.
// Revision : 1.0
// ============================================================================
package nco_pkg;

    localparam int unsigned c_nco_bits      = 4;
    localparam int unsigned c_nco_freq_bits = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        MEASURE = 2'd2
    } meter_state_t;

endpackage
`default_nettype wire

// File: rtl/nco_freq_meter_if.sv
`default_nettype none
// ============================================================================
// Interface : nco_freq_meter_if
// Brief     : Enable/signal inputs and measurement result outputs of the meter.
// Revision  : 1.0
// ============================================================================
interface nco_freq_meter_if
    import nco_pkg::*;
#(
    parameter int NCO_FREQ_BITS = c_nco_freq_bits
) ();

    logic                     en_in;
    logic                     sig_in;
    logic [NCO_FREQ_BITS-1:0] fcw_out;
    logic                     valid_out;
    logic                     ovf_out;

    modport master (
        output en_in, sig_in,
        input  fcw_out, valid_out, ovf_out
    );

    modport slave (
        input  en_in, sig_in,
        output fcw_out, valid_out, ovf_out
    );

endinterface
`default_nettype wire

// File: rtl/nco_freq_meter_sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Brief    : Synchronizer chain plus previous-sample flop; flags rising edges.
// Revision : 1.0
// ============================================================================
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic sig_in,
    output logic rise_out
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    generate
        if (SYNC_STAGES == 1) begin : g_single
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) r_sync <= '0;
                else        r_sync <= sig_in;
            end
        end else begin : g_chain
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) r_sync <= '0;
                else        r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            end
        end
    endgenerate

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_prev <= 1'b0;
        else        r_prev <= r_sync[SYNC_STAGES-1];
    end

    assign rise_out = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/nco_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : nco_freq_meter
// Brief    : Counts rising edges over a 2^GATE_BITS gate to recover an NCO fcw.
// Revision : 1.0
// ============================================================================
module nco_freq_meter
    import nco_pkg::*;
#(
    parameter int NCO_BITS      = c_nco_bits,
    parameter int NCO_FREQ_BITS = c_nco_freq_bits,
    parameter int GATE_BITS     = NCO_BITS,
    parameter int SYNC_STAGES   = 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    nco_freq_meter_if.slave bus
);

    localparam int c_res_w = (GATE_BITS + 1 > NCO_FREQ_BITS) ? GATE_BITS + 1 : NCO_FREQ_BITS;
    localparam logic [c_res_w-1:0] c_fcw_max = c_res_w'((1 << NCO_FREQ_BITS) - 1);

    meter_state_t             r_state;
    meter_state_t             w_state_nxt;
    logic [GATE_BITS-1:0]     r_gate_cnt;
    logic [GATE_BITS:0]       r_edge_cnt;
    logic [NCO_FREQ_BITS-1:0] r_fcw;
    logic                     r_valid;
    logic                     r_ovf;

    logic                     w_rise;
    logic                     w_term;
    logic                     w_cnt_clr;
    logic                     w_cnt_run;
    logic                     w_latch;
    logic [c_res_w-1:0]       w_total;
    logic                     w_sat;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .sig_in   (bus.sig_in),
        .rise_out (w_rise)
    );

    assign w_term = &r_gate_cnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_run   = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_clr = 1'b1;
                if (bus.en_in) w_state_nxt = WARMUP;
            end
            WARMUP: begin
                w_cnt_run = 1'b1;
                if (w_term) begin
                    w_state_nxt = MEASURE;
                    w_cnt_clr   = 1'b1;
                end
            end
            MEASURE: begin
                w_cnt_run = 1'b1;
                if (w_term) begin
                    w_latch   = 1'b1;
                    w_cnt_clr = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_clr   = 1'b1;
            end
        endcase
        // Dropping enable abandons the window from any state without a result.
        if (!bus.en_in) begin
            w_state_nxt = IDLE;
            w_cnt_clr   = 1'b1;
            w_cnt_run   = 1'b0;
            w_latch     = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
        end else if (w_cnt_run) begin
            r_gate_cnt <= r_gate_cnt + GATE_BITS'(1);
            r_edge_cnt <= r_edge_cnt + (GATE_BITS + 1)'(w_rise);
        end
    end

    // The closing window includes a rise seen on its own terminal-count cycle.
    assign w_total = c_res_w'(r_edge_cnt) + c_res_w'(w_rise);
    assign w_sat   = (w_total > c_fcw_max);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_fcw   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= w_latch;
            if (w_latch) begin
                r_fcw <= w_sat ? {NCO_FREQ_BITS{1'b1}} : w_total[NCO_FREQ_BITS-1:0];
                r_ovf <= w_sat;
            end
        end
    end

    assign bus.fcw_out   = r_fcw;
    assign bus.valid_out = r_valid;
    assign bus.ovf_out   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nco_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nco_freq_meter
// Brief    : Self-checking bench for nco_freq_meter (4-bit and 6-bit gate).
// Revision : 1.0
// ============================================================================
module tb_nco_freq_meter;

    localparam int c_sync = 2;
    localparam int c_hist = 1024;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    nco_freq_meter_if #(.NCO_FREQ_BITS(4)) bus4 ();
    nco_freq_meter_if #(.NCO_FREQ_BITS(4)) bus6 ();

    logic en4 = 1'b0;
    logic en6 = 1'b0;
    logic sig = 1'b0;

    assign bus4.en_in  = en4;
    assign bus4.sig_in = sig;
    assign bus6.en_in  = en6;
    assign bus6.sig_in = sig;

    nco_freq_meter #(
        .NCO_BITS(4), .NCO_FREQ_BITS(4), .GATE_BITS(4), .SYNC_STAGES(c_sync)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus4)
    );

    nco_freq_meter #(
        .NCO_BITS(4), .NCO_FREQ_BITS(4), .GATE_BITS(6), .SYNC_STAGES(c_sync)
    ) dut6 (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus6)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic hist [c_hist];

    // Stimulus source: 0 constant, 1 NCO MSB, 2 random bits, 3 toggle every cycle
    int   mode      = 0;
    logic const_val = 1'b0;
    int   fcw       = 0;
    int   phase     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: record what the DUT samples at this edge, change sig, end on negedge.
    task automatic tick();
        @(posedge clk_in);
        cyc = cyc + 1;
        hist[cyc % c_hist] = sig;
        #2;
        case (mode)
            0:       sig = const_val;
            1: begin
                phase = (phase + fcw) % 16;
                sig   = (phase >= 8);
            end
            2:       sig = 1'($urandom_range(0, 1));
            default: sig = ~sig;
        endcase
        @(negedge clk_in);
    endtask

    // Rising edges of the input as seen through the synchronizer delay, counted
    // over the len gate cycles ending at edge b.
    function automatic int model_count(input int b, input int len);
        int n = 0;
        for (int m = b - len + 1; m <= b; m++) begin
            if (hist[(m - c_sync) % c_hist] === 1'b1 && hist[(m - c_sync - 1) % c_hist] === 1'b0)
                n++;
        end
        return n;
    endfunction

    task automatic next_valid(input int which, input string tag, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((which == 6 ? bus6.valid_out : bus4.valid_out) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        checks++;
        assert (at >= 0) else begin
            errors++;
            $error("FAIL %s timeout observed=no_valid expected=valid_pulse", tag);
        end
    endtask

    task automatic measure(input int which, input string tag, input int budget,
                           input int exp_at, output int at);
        int   n;
        logic [3:0] ef;
        logic eo;
        next_valid(which, tag, budget, at);
        if (at < 0) return;
        chk({tag, "_time"}, 32'(at), 32'(exp_at));
        n  = model_count(at, (which == 6) ? 64 : 16);
        ef = (n > 15) ? 4'hF : 4'(n);
        eo = (n > 15);
        if (which == 6) begin
            chk({tag, "_fcw"}, 32'(bus6.fcw_out), 32'(ef));
            chk({tag, "_ovf"}, 32'(bus6.ovf_out), 32'(eo));
        end else begin
            chk({tag, "_fcw"}, 32'(bus4.fcw_out), 32'(ef));
            chk({tag, "_ovf"}, 32'(bus4.ovf_out), 32'(eo));
        end
    endtask

    initial begin
        int   at;
        int   e;
        int   f;
        int   held_fcw;
        int   held_ovf;
        logic bad;

        // Reset state
        for (int i = 0; i < 4; i++) tick();
        chk("rst_valid",  32'(bus4.valid_out), 32'd0);
        chk("rst_fcw",    32'(bus4.fcw_out),   32'd0);
        chk("rst_ovf",    32'(bus4.ovf_out),   32'd0);
        chk("rst_valid6", 32'(bus6.valid_out), 32'd0);
        rst_in = 1'b0;
        tick();

        // NCO fcw=1: first result 33 cycles after enable, then every 16
        mode = 1; fcw = 1; phase = 0;
        tick(); tick();
        en4 = 1'b1; e = cyc + 1;
        measure(4, "t1_first", 64, e + 32, at);
        chk("t1_fcw1", 32'(bus4.fcw_out), 32'd1);
        for (int k = 0; k < 3; k++) begin
            measure(4, "t1_next", 40, at + 16, at);
            chk("t1_steady", 32'(bus4.fcw_out), 32'd1);
        end

        // Unaligned fcw changes: mixed window, then exact
        for (int i = 0; i < 5; i++) tick();
        fcw = 2;
        for (int k = 0; k < 3; k++) measure(4, "t2_to2", 40, at + 16, at);
        chk("t2_fcw2", 32'(bus4.fcw_out), 32'd2);
        for (int i = 0; i < 7; i++) tick();
        fcw = 4;
        for (int k = 0; k < 3; k++) measure(4, "t2_to4", 40, at + 16, at);
        chk("t2_fcw4", 32'(bus4.fcw_out), 32'd4);

        // Random fcw: exact up to 8, aliased to 16-fcw above
        for (int r = 0; r < 5; r++) begin
            f = int'($urandom_range(0, 15));
            for (int i = 0; i < 3; i++) tick();
            fcw = f;
            for (int k = 0; k < 3; k++) measure(4, "t_alias", 40, at + 16, at);
            chk("t_alias_rule", 32'(bus4.fcw_out), 32'((f <= 8) ? f : 16 - f));
        end

        // Random input bits against the edge-count model
        mode = 2;
        for (int k = 0; k < 8; k++) measure(4, "t_rand", 40, at + 16, at);

        // Input held high, then low: zero edges, no spurious edge at enable
        en4 = 1'b0; mode = 0; const_val = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        en4 = 1'b1; e = cyc + 1;
        measure(4, "t3_hi", 64, e + 32, at);
        chk("t3_hi_fcw", 32'(bus4.fcw_out), 32'd0);
        measure(4, "t3_hi2", 40, at + 16, at);
        const_val = 1'b0;
        measure(4, "t3_lo", 40, at + 16, at);
        measure(4, "t3_lo2", 40, at + 16, at);
        chk("t3_lo_fcw", 32'(bus4.fcw_out), 32'd0);

        // 64-cycle gate, 32 edges per window: saturates with overflow
        en4 = 1'b0; mode = 3; en6 = 1'b1; e = cyc + 1;
        measure(6, "t4_first", 200, e + 128, at);
        chk("t4_fcw", 32'(bus6.fcw_out), 32'd15);
        chk("t4_ovf", 32'(bus6.ovf_out), 32'd1);
        measure(6, "t4_next", 80, at + 64, at);
        chk("t4_fcw2", 32'(bus6.fcw_out), 32'd15);
        en6 = 1'b0;

        // Enable dropped mid-window: no result, outputs hold, full warm-up on return
        mode = 2; en4 = 1'b1; e = cyc + 1;
        measure(4, "t5_first", 64, e + 32, at);
        held_fcw = int'(bus4.fcw_out);
        held_ovf = int'(bus4.ovf_out);
        for (int i = 0; i < 5; i++) tick();
        en4 = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus4.valid_out !== 1'b0) bad = 1'b1;
        end
        chk("t5_novalid", 32'(bad), 32'd0);
        chk("t5_hold_fcw", 32'(bus4.fcw_out), 32'(held_fcw));
        chk("t5_hold_ovf", 32'(bus4.ovf_out), 32'(held_ovf));
        en4 = 1'b1; e = cyc + 1;
        measure(4, "t5_reen", 64, e + 32, at);

        // Asynchronous reset between edges mid-window
        mode = 3;
        measure(4, "t6_a", 40, at + 16, at);
        measure(4, "t6_b", 40, at + 16, at);
        chk("t6_fcw8", 32'(bus4.fcw_out), 32'd8);
        for (int i = 0; i < 6; i++) tick();
        #2;
        rst_in = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(bus4.valid_out), 32'd0);
        chk("t6_rst_fcw",   32'(bus4.fcw_out),   32'd0);
        chk("t6_rst_ovf",   32'(bus4.ovf_out),   32'd0);
        tick(); tick();
        rst_in = 1'b0; e = cyc + 1;
        measure(4, "t6_post", 64, e + 32, at);
        chk("t6_post_fcw", 32'(bus4.fcw_out), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
